// File: rtl/vga_stream_timing_gen.sv
// VGA timing generator: parametrised h/v timing, pixel-clock divider, valid/ready pixel stream input.
// Optional colour-bar test pattern is compiled in when VGA_TEST_PATTERN_EN is defined.
module vga_stream_timing_gen #(
  parameter int COLOR_BITS = 1,
  parameter int CLK_DIV    = 1,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 48,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 29,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter logic [3*COLOR_BITS-1:0] UF_COLOR = '0
) (
  input  logic                      CLOCK_50,
  input  logic                      KEY,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  input  logic [3*COLOR_BITS-1:0]   pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      frame_start,
  output logic [15:0]               underflow_cnt,
  output logic [COLOR_BITS-1:0]     VGA_RED,
  output logic [COLOR_BITS-1:0]     VGA_GREEN,
  output logic [COLOR_BITS-1:0]     VGA_BLUE,
  output logic                      VGA_HSYNC,
  output logic                      VGA_VSYNC
);

  localparam int CW       = 3 * COLOR_BITS;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;
  logic [15:0]   uf_q, uf_d;

  logic          tick, active, hs_on, vs_on, fs_tick;
  logic          test_eff;
  logic [CW-1:0] bar_rgb;
  int            h_i, v_i;

  always_comb begin
    h_i     = int'(h_q);
    v_i     = int'(v_q);
    tick    = (div_q == DIV_LAST);
    active  = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    hs_on   = (h_i >= HS_START) && (h_i < HS_END);
    vs_on   = (v_i >= VS_START) && (v_i < VS_END);
    fs_tick = tick && (h_q == '0) && (v_q == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic       test_q, test_d;
  logic [2:0] bar;
  int         bar_i;

  // test_mode is only sampled at the (0,0) tick so a frame is never half pattern.
  always_comb begin
    test_d   = fs_tick ? test_mode : test_q;
    test_eff = test_d;
    bar_i    = h_i / BAR_W;
    if (bar_i > 7) bar_i = 7;
    bar      = 3'(bar_i);
    bar_rgb  = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
  end
`else
  assign test_eff = 1'b0;
  assign bar_rgb  = '0;
`endif

  assign pix_ready = tick && active && KEY && !test_eff;

  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    uf_d          = uf_q;

    if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end

      // Outputs capture the current position, so they lag the counters by one tick.
      hsync_d       = hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = vs_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start_d = fs_tick;
      if (!active) begin
        rgb_d = '0;
      end else if (test_eff) begin
        rgb_d = bar_rgb;
      end else if (pix_valid) begin
        rgb_d = pix_data;
      end else begin
        rgb_d = UF_COLOR;
        if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rgb_q         <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      uf_q          <= '0;
`ifdef VGA_TEST_PATTERN_EN
      test_q        <= 1'b0;
`endif
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      uf_q          <= uf_d;
`ifdef VGA_TEST_PATTERN_EN
      test_q        <= test_d;
`endif
    end
  end

  assign VGA_RED       = rgb_q[CW-1 -: COLOR_BITS];
  assign VGA_GREEN     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign VGA_BLUE      = rgb_q[COLOR_BITS-1:0];
  assign VGA_HSYNC     = hsync_q;
  assign VGA_VSYNC     = vsync_q;
  assign frame_start   = frame_start_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_vga_stream_timing_gen.sv
// Bench for vga_stream_timing_gen: small 14x9 raster at CLK_DIV=1 (dut_a) and CLK_DIV=4 (dut_b).
module tb_vga_stream_timing_gen;

  localparam int HT = 14;
  localparam int VT = 9;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        key_a, key_b;
  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b, fs_a, fs_b;
  logic [15:0] uf_a, uf_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, hs_b, vs_b;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  vga_stream_timing_gen #(
    .COLOR_BITS(4), .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .UF_COLOR(12'hF00)
  ) dut_a (
    .CLOCK_50(clk), .KEY(key_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_data(data_a), .pix_valid(valid_a), .pix_ready(ready_a),
    .frame_start(fs_a), .underflow_cnt(uf_a),
    .VGA_RED(r_a), .VGA_GREEN(g_a), .VGA_BLUE(b_a),
    .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a)
  );

  vga_stream_timing_gen #(
    .COLOR_BITS(4), .CLK_DIV(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .UF_COLOR(12'hF00)
  ) dut_b (
    .CLOCK_50(clk), .KEY(key_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .frame_start(fs_b), .underflow_cnt(uf_b),
    .VGA_RED(r_b), .VGA_GREEN(g_b), .VGA_BLUE(b_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b)
  );

  typedef struct {
    int   off;
    logic hs;
    logic vs;
    logic blank;
  } vec_t;

  vec_t        tbl[15];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mh = 0;
  int          mv = 0;
  int          uf_model = 0;
  int          xfer_total = 0;
  logic [11:0] sb_q[$];
  int          fs_list[$];
  int          xcum[0:1023];
  logic        hs_log[0:1023];
  logic        vs_log[0:1023];
  logic [11:0] rgb_log[0:1023];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  // One pixel clock of dut_a: predict the pins from the bench's own raster position, then compare.
  task automatic step_a();
    logic        act;
    logic        dut_xfer;
    logic [11:0] exp_rgb;
    #1;
    act = (mh < 8) && (mv < 4);
    chk("a_ready", ready_a, act);
    dut_xfer = ready_a && valid_a;
    if (act) exp_rgb = valid_a ? data_a : 12'hF00;
    else     exp_rgb = 12'h000;
    sb_q.push_back(exp_rgb);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (act && valid_a) data_a = data_a + 12'd1;
    if (act && !valid_a) uf_model++;
    if (dut_xfer) xfer_total++;
    chk("a_rgb_sb", {r_a, g_a, b_a}, sb_q.pop_front());
    if (fs_a) fs_list.push_back(cyc);
    if (cyc < 1024) begin
      xcum[cyc]    = xfer_total;
      hs_log[cyc]  = hs_a;
      vs_log[cyc]  = vs_a;
      rgb_log[cyc] = {r_a, g_a, b_a};
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  initial begin
    int base, guard, rs_cyc, cb, rdy_viol, chg_viol, f0_xfers;
    logic accb;
    logic [11:0] expb;
    logic [13:0] prevb;
    int fsb[$];
    int bland[$];

    // offset from a frame_start cycle -> expected hsync, vsync, colour forced to zero
    tbl[0]  = '{0,  1'b1, 1'b1, 1'b0};
    tbl[1]  = '{7,  1'b1, 1'b1, 1'b0};
    tbl[2]  = '{8,  1'b1, 1'b1, 1'b1};
    tbl[3]  = '{9,  1'b1, 1'b1, 1'b1};
    tbl[4]  = '{10, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{11, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{12, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{13, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{24, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{57, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{69, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{70, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{80, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{83, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{84, 1'b1, 1'b1, 1'b1};

    key_a = 1'b0; key_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 12'h000; data_b = 12'h100;
    xcum[0] = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rgb", {r_a, g_a, b_a}, 0);
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_fs", fs_a, 0);
    chk("rst_uf", uf_a, 0);
    chk("rst_ready", ready_a, 0);

    // Two full frames with a always-valid incrementing stream
    key_a = 1'b1;
    valid_a = 1'b1;
    repeat (2 * FRAME + 20) step_a();
    chk("fs_count", fs_list.size(), 3);
    if (fs_list.size() >= 3) begin
      chk("fs_first", fs_list[0], 1);
      chk("fs_period0", fs_list[1] - fs_list[0], FRAME);
      chk("fs_period1", fs_list[2] - fs_list[1], FRAME);
      chk("xfers_frame0", xcum[fs_list[1] - 1] - xcum[fs_list[0] - 1], 32);
      base = fs_list[1];
      for (int i = 0; i < 15; i++) begin
        chk($sformatf("tbl%0d_hs", tbl[i].off), hs_log[base + tbl[i].off], tbl[i].hs);
        chk($sformatf("tbl%0d_vs", tbl[i].off), vs_log[base + tbl[i].off], tbl[i].vs);
        if (tbl[i].blank) chk($sformatf("tbl%0d_rgb", tbl[i].off), rgb_log[base + tbl[i].off], 0);
      end
    end

    // Underflow: drop valid for pixels (1,0),(2,0),(3,0)
    guard = 0;
    while (!(mh == 1 && mv == 0) && guard < 300) begin
      step_a();
      guard++;
    end
    chk("uf_align_timeout", guard < 300, 1);
    valid_a = 1'b0;
    repeat (3) step_a();
    chk("uf_cnt", uf_a, 3);
    chk("uf_model", uf_a, uf_model);
    valid_a = 1'b1;
    repeat (5) step_a();

    // Reset for one cycle in the middle of a line
    guard = 0;
    while (!(mh == 4 && mv == 1) && guard < 300) begin
      step_a();
      guard++;
    end
    key_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("mid_rst_rgb", {r_a, g_a, b_a}, 0);
    chk("mid_rst_hsync", hs_a, 1);
    chk("mid_rst_vsync", vs_a, 1);
    chk("mid_rst_fs", fs_a, 0);
    chk("mid_rst_uf", uf_a, 0);
    chk("mid_rst_ready", ready_a, 0);
    key_a = 1'b1;
    rs_cyc = cyc;
    mh = 0; mv = 0; uf_model = 0;
    sb_q.delete();
    fs_list.delete();
    repeat (FRAME + 4) step_a();
    chk("post_rst_fs_count", fs_list.size(), 2);
    if (fs_list.size() >= 2) begin
      chk("post_rst_fs_first", fs_list[0] - rs_cyc, 1);
      chk("post_rst_fs_period", fs_list[1] - fs_list[0], FRAME);
    end

    // CLK_DIV=4 instance
    key_b = 1'b1;
    valid_b = 1'b1;
    cb = 0; rdy_viol = 0; chg_viol = 0;
    for (int i = 0; i < 4 * FRAME * 2 + 90; i++) begin
      #1;
      accb = ready_b && valid_b;
      if (ready_b && (cb % 4) != 3) rdy_viol++;
      expb = data_b;
      if (accb) bland.push_back(cb + 1);
      prevb = {r_b, g_b, b_b, hs_b, vs_b};
      @(posedge clk);
      @(negedge clk);
      cb++;
      if (accb) begin
        data_b = data_b + 12'd1;
        chk("b_rgb", {r_b, g_b, b_b}, expb);
      end
      if ({r_b, g_b, b_b, hs_b, vs_b} != prevb && (cb % 4) != 0) chg_viol++;
      if (fs_b) fsb.push_back(cb);
    end
    chk("b_ready_phase", rdy_viol, 0);
    chk("b_change_phase", chg_viol, 0);
    chk("b_uf", uf_b, 0);
    chk("b_fs_count", fsb.size(), 3);
    if (fsb.size() >= 3) begin
      chk("b_fs_first", fsb[0], 4);
      chk("b_fs_period0", fsb[1] - fsb[0], 4 * FRAME);
      chk("b_fs_period1", fsb[2] - fsb[1], 4 * FRAME);
      f0_xfers = 0;
      foreach (bland[k]) if (bland[k] >= fsb[0] && bland[k] < fsb[1]) f0_xfers++;
      chk("b_xfers_frame0", f0_xfers, 32);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
